// File: rtl/genius_pkg.sv
// Shared encodings for the Genius/Simon datapath: FSM states and count direction.
package genius_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;
endpackage

// File: rtl/seq_step_prescaler.sv
// Turns every PRESCALE-th E strobe into one address step; clr restarts the count.
module seq_step_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic R,
  input  logic clr,
  input  logic E,
  output logic step
);
  localparam int CW = $clog2(PRESCALE) + 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign step = E && !clr && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr || step) cnt_d = '0;
    else if (E)      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge R) begin
    if (!R) cnt_q <= '0;
    else    cnt_q <= cnt_d;
  end
endmodule

// File: rtl/seq_addr_counter.sv
// ROM address sequencer for one round: 0..limit or limit..0 with start/abort handshake.
// Optional E prescaling is enabled by defining SEQ_CNT_PRESCALE_EN.
module seq_addr_counter
  import genius_pkg::*;
#(
  parameter int W        = 4,
  parameter int PRESCALE = 4
) (
  input  logic         clk,
  input  logic         R,
  input  logic         start,
  input  logic         abort,
  input  logic         E,
  input  logic         dir,
  input  logic [W-1:0] limit,
  output logic [W-1:0] SEQFPGA,
  output logic         valid,
  output logic         tc,
  output logic         done,
  output logic         busy
);
  state_e       state_q, state_d;
  logic [W-1:0] addr_q, addr_d;
  logic [W-1:0] lim_q, lim_d;
  logic         dir_q, dir_d;
  logic         run, at_end, step;
  logic [W-1:0] end_addr;

  assign run      = (state_q == ST_RUN);
  assign end_addr = (dir_q == DIR_DOWN) ? '0 : lim_q;
  assign at_end   = (addr_q == end_addr);

`ifdef SEQ_CNT_PRESCALE_EN
  logic clr;
  assign clr = abort || (state_q == ST_IDLE && start);

  // only E strobes seen in RUN advance the prescale count
  seq_step_prescaler #(.PRESCALE(PRESCALE)) u_pre (
    .clk  (clk),
    .R    (R),
    .clr  (clr),
    .E    (E && run),
    .step (step)
  );
`else
  // a PRESCALE below 1 is illegal in either build; folds to plain E otherwise
  assign step = E && (PRESCALE >= 1);
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    lim_d   = lim_q;
    dir_d   = dir_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: if (start) begin
          lim_d   = limit;
          dir_d   = dir;
          addr_d  = (dir == DIR_DOWN) ? limit : '0;
          state_d = ST_RUN;
        end
        ST_RUN: if (step) begin
          if (at_end)                state_d = ST_DONE;
          else if (dir_q == DIR_DOWN) addr_d = addr_q - W'(1);
          else                        addr_d = addr_q + W'(1);
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      lim_q   <= '0;
      dir_q   <= DIR_UP;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      lim_q   <= lim_d;
      dir_q   <= dir_d;
    end
  end

  assign SEQFPGA = addr_q;
  assign valid   = run;
  assign tc      = run && at_end;
  assign done    = (state_q == ST_DONE);
  assign busy    = (state_q != ST_IDLE);
endmodule

// File: tb/tb_seq_addr_counter.sv
// Table-driven bench for seq_addr_counter (W=4, PRESCALE=4) with an expected-output queue.
module tb_seq_addr_counter;
`ifdef SEQ_CNT_PRESCALE_EN
  localparam int PS = 4;
`else
  localparam int PS = 1;
`endif

  logic       clk = 1'b0;
  logic       R;
  logic       start, abort, E, dir;
  logic [3:0] limit;
  logic [3:0] SEQFPGA;
  logic       valid, tc, done, busy;

  seq_addr_counter #(.W(4), .PRESCALE(4)) dut (
    .clk(clk), .R(R), .start(start), .abort(abort), .E(E), .dir(dir),
    .limit(limit), .SEQFPGA(SEQFPGA), .valid(valid), .tc(tc), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] a;
    logic       v, tc, dn, bz;
  } out_t;

  typedef struct {
    string      nm;
    logic       st, ab, e, dr;
    logic [3:0] lim;
    out_t       exp;
  } vec_t;

  out_t  q[$];
  string nq[$];
  vec_t  tbl[$];
  out_t  cur;
  int    total = 0;
  int    bad   = 0;

  function automatic vec_t mk(string nm, logic st, logic ab, logic e, logic dr,
                              logic [3:0] lim, logic [3:0] a,
                              logic v, logic t, logic dn, logic bz);
    vec_t r;
    r.nm = nm; r.st = st; r.ab = ab; r.e = e; r.dr = dr; r.lim = lim;
    r.exp = '{a: a, v: v, tc: t, dn: dn, bz: bz};
    return r;
  endfunction

  task automatic drive(logic st, logic ab, logic e, logic dr, logic [3:0] lim);
    start = st; abort = ab; E = e; dir = dr; limit = lim;
  endtask

  task automatic compare(string nm, out_t exp);
    out_t got;
    got = '{a: SEQFPGA, v: valid, tc: tc, dn: done, bz: busy};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got a=%0d v=%0b tc=%0b done=%0b busy=%0b, expected a=%0d v=%0b tc=%0b done=%0b busy=%0b",
               nm, got.a, got.v, got.tc, got.dn, got.bz, exp.a, exp.v, exp.tc, exp.dn, exp.bz);
    end
  endtask

  task automatic tick_check();
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard: queue empty, expected an entry");
    end else begin
      compare(nq.pop_front(), q.pop_front());
    end
  endtask

  // One logical step may need PS-1 extra E pulses that must leave the outputs alone
  task automatic apply(vec_t v);
    if (v.e && !v.st && !v.ab)
      for (int k = 0; k < PS - 1; k++) begin
        drive(1'b0, 1'b0, 1'b1, v.dr, v.lim);
        q.push_back(cur); nq.push_back({v.nm, "_pre"});
        tick_check();
      end
    drive(v.st, v.ab, v.e, v.dr, v.lim);
    q.push_back(v.exp); nq.push_back(v.nm);
    tick_check();
    cur = v.exp;
    drive(1'b0, 1'b0, 1'b0, v.dr, v.lim);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    R = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    #12;
    compare("reset_state", '0);
    @(negedge clk) R = 1'b1;
    @(posedge clk); #1;
    cur = '0;

    // up count 0..3
    tbl.push_back(mk("t2_start", 1,0,0,0,4'd3, 4'd0, 1,0,0,1));
    tbl.push_back(mk("t2_e1",    0,0,1,0,4'd3, 4'd1, 1,0,0,1));
    tbl.push_back(mk("t2_e2",    0,0,1,0,4'd3, 4'd2, 1,0,0,1));
    tbl.push_back(mk("t2_e3",    0,0,1,0,4'd3, 4'd3, 1,1,0,1));
    tbl.push_back(mk("t2_e4",    0,0,1,0,4'd3, 4'd3, 0,0,1,1));
    tbl.push_back(mk("t2_idle",  0,0,0,0,4'd3, 4'd3, 0,0,0,0));
    // down count 2..0, limit/dir wiggled mid-run
    tbl.push_back(mk("t3_start", 1,0,0,1,4'd2, 4'd2, 1,0,0,1));
    tbl.push_back(mk("t3_e1",    0,0,1,1,4'd9, 4'd1, 1,0,0,1));
    tbl.push_back(mk("t3_e2",    0,0,1,0,4'd9, 4'd0, 1,1,0,1));
    tbl.push_back(mk("t3_e3",    0,0,1,0,4'd9, 4'd0, 0,0,1,1));
    tbl.push_back(mk("t3_idle",  0,0,0,0,4'd0, 4'd0, 0,0,0,0));
    // single-address run
    tbl.push_back(mk("t4_start", 1,0,0,0,4'd0, 4'd0, 1,1,0,1));
    tbl.push_back(mk("t4_e1",    0,0,1,0,4'd0, 4'd0, 0,0,1,1));
    tbl.push_back(mk("t4_idle",  0,0,0,0,4'd0, 4'd0, 0,0,0,0));
    // simultaneous events
    tbl.push_back(mk("t5_abst",   1,1,0,0,4'd7, 4'd0, 0,0,0,0));
    tbl.push_back(mk("t5_idle",   0,0,0,0,4'd7, 4'd0, 0,0,0,0));
    tbl.push_back(mk("t5_start",  1,0,0,0,4'd5, 4'd0, 1,0,0,1));
    tbl.push_back(mk("t5_e1",     0,0,1,0,4'd5, 4'd1, 1,0,0,1));
    tbl.push_back(mk("t5_abE",    0,1,1,0,4'd5, 4'd1, 0,0,0,0));
    tbl.push_back(mk("t5_post",   0,0,0,0,4'd5, 4'd1, 0,0,0,0));
    tbl.push_back(mk("t5_start2", 1,0,0,0,4'd5, 4'd0, 1,0,0,1));
    tbl.push_back(mk("t5_stRun",  1,0,0,1,4'd9, 4'd0, 1,0,0,1));
    tbl.push_back(mk("t5_e",      0,0,1,1,4'd9, 4'd1, 1,0,0,1));
    tbl.push_back(mk("t5_abort",  0,1,0,0,4'd9, 4'd1, 0,0,0,0));
    // limit=1 run and E while idle
    tbl.push_back(mk("t6_start", 1,0,0,0,4'd1, 4'd0, 1,0,0,1));
    tbl.push_back(mk("t6_e1",    0,0,1,0,4'd1, 4'd1, 1,1,0,1));
    tbl.push_back(mk("t6_e2",    0,0,1,0,4'd1, 4'd1, 0,0,1,1));
    tbl.push_back(mk("t6_idle",  0,0,0,0,4'd1, 4'd1, 0,0,0,0));
    tbl.push_back(mk("t6_idleE", 0,0,1,0,4'd1, 4'd1, 0,0,0,0));

    foreach (tbl[i]) apply(tbl[i]);

    // full-range up count must stop at 15, never wrap
    apply(mk("t15_start", 1,0,0,0,4'd15, 4'd0, 1,0,0,1));
    for (int i = 1; i < 16; i++)
      apply(mk($sformatf("t15_e%0d", i), 0,0,1,0,4'd15, 4'(i), 1,(i == 15),0,1));
    apply(mk("t15_end",  0,0,1,0,4'd15, 4'd15, 0,0,1,1));
    apply(mk("t15_idle", 0,0,0,0,4'd15, 4'd15, 0,0,0,0));

    // asynchronous reset in the middle of a run at address 3
    apply(mk("t1_start", 1,0,0,0,4'd5, 4'd0, 1,0,0,1));
    apply(mk("t1_e1",    0,0,1,0,4'd5, 4'd1, 1,0,0,1));
    apply(mk("t1_e2",    0,0,1,0,4'd5, 4'd2, 1,0,0,1));
    apply(mk("t1_e3",    0,0,1,0,4'd5, 4'd3, 1,0,0,1));
    #2 R = 1'b0;
    #1 compare("t1_async_reset", '0);
    @(negedge clk) R = 1'b1;
    @(posedge clk); #1;
    cur = '0;
    apply(mk("t1_after", 0,0,1,0,4'd5, 4'd0, 0,0,0,0));

    if (q.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
